// File: rtl/base_pkg.sv
// Shared helpers for the base_* stream cells: index-width rule and binary-to-one-hot decode.
package base_pkg;

    localparam int unsigned MaxWays = 64;

    function automatic int unsigned sel_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Out-of-range indices decode to all zeros.
    function automatic logic [MaxWays-1:0] onehot_dec(input int unsigned sel,
                                                      input int unsigned ways);
        logic [MaxWays-1:0] res;
        res = '0;
        if ((sel < ways) && (sel < MaxWays)) begin
            res = MaxWays'(1) << sel;
        end
        return res;
    endfunction

endpackage

// File: rtl/base_decode_le.sv
// Combinational binary-to-one-hot lane decoder with a separate out-of-range check.
module base_decode_le
    import base_pkg::*;
#(
    parameter int unsigned ways      = 2,
    parameter int unsigned sel_width = sel_bits(ways)
) (
    input  logic [sel_width-1:0] sel_i,
    input  logic                 en_i,
    output logic [ways-1:0]      onehot_o,
    input  logic [sel_width-1:0] chk_i,
    output logic                 oor_o
);

    logic [MaxWays-1:0] dec;
    logic               unused_dec;

    always_comb begin
        dec      = onehot_dec(32'(sel_i), ways);
        onehot_o = en_i ? dec[ways-1:0] : '0;
        oor_o    = (32'(chk_i) >= ways);
    end

    assign unused_dec = ^dec;

endmodule

// File: rtl/base_edemux_le.sv
// Binary-select stream demux: one-entry output register steered onto one of `ways` lanes;
// illegal way indices are consumed, flagged for one cycle and counted.
module base_edemux_le
    import base_pkg::*;
#(
    parameter int unsigned width     = 1,
    parameter int unsigned ways      = 2,
    parameter int unsigned sel_width = sel_bits(ways),
    parameter int unsigned cnt_width = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_v,
    output logic                  i_r,
    input  logic [sel_width-1:0]  i_sel,
    input  logic [width-1:0]      i_d,
    output logic [ways-1:0]       o_v,
    input  logic [ways-1:0]       o_r,
    output logic [width*ways-1:0] o_d,
    output logic                  o_err,
    output logic [cnt_width-1:0]  o_drop_cnt
);

    logic                 full_q, full_d;
    logic [sel_width-1:0] sel_q, sel_d;
    logic [width-1:0]     d_q, d_d;
    logic                 err_q, err_d;
    logic [cnt_width-1:0] drop_q, drop_d;

    logic illegal;
    logic drain;
    logic acc;

    base_decode_le #(
        .ways      (ways),
        .sel_width (sel_width)
    ) u_decode (
        .sel_i    (sel_q),
        .en_i     (full_q),
        .onehot_o (o_v),
        .chk_i    (i_sel),
        .oor_o    (illegal)
    );

    // o_v is already gated by full, so this is full & o_r[sel_q].
    assign drain = |(o_v & o_r);
    assign i_r   = ~full_q | drain;
    assign acc   = i_v & i_r;

    always_comb begin
        full_d = full_q;
        sel_d  = sel_q;
        d_d    = d_q;
        err_d  = 1'b0;
        drop_d = drop_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (acc && !illegal) begin
            full_d = 1'b1;
            sel_d  = i_sel;
            d_d    = i_d;
        end
        if (acc && illegal) begin
            err_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + cnt_width'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            sel_q  <= '0;
            d_q    <= '0;
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            full_q <= full_d;
            sel_q  <= sel_d;
            d_q    <= d_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    for (genvar k = 0; k < ways; k++) begin : g_lane
        assign o_d[k*width +: width] = o_v[k] ? d_q : '0;
    end

    assign o_err      = err_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: doc/base_edemux_le.md
Name: base_edemux_le

Overview:
- Binary-select stream demultiplexer: the write-side counterpart of the encoded mux cells.
- Accepts one valid/ready input beat plus a binary way index. Holds the beat in a single-entry output register and presents it on exactly one of `ways` packed output lanes.
- Used wherever a single producer fans out to per-way consumers, e.g. per-engine command queues. Full throughput: one beat per cycle.
- Illegal indices, possible when `ways` is not a power of two, are absorbed and counted.

Parameters:
- width, 1, data bits per beat
- ways, 2, number of output lanes (≥2)
- sel_width, $clog2(ways), width of way index
- cnt_width, 8, width of saturating drop counter

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- i_v  input  1  input beat valid
- i_r  output  1  input ready
- i_sel  input  sel_width  destination way for the input beat
- i_d  input  width  input data
- o_v  output  ways  per-way valid; at most one bit set
- o_r  input  ways  per-way ready
- o_d  output  width*ways  packed per-way data; lane k at [(k+1)*width-1 : k*width]
- o_err  output  1  one-cycle pulse: an illegal-sel beat was dropped
- o_drop_cnt  output  cnt_width  saturating count of dropped beats

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n, sampled on rising clk.
- State: full (1b), sel_q (sel_width), d_q (width), err_q, drop_cnt.
- Reset values: full=0, o_v=0, o_d=0, o_err=0, o_drop_cnt=0. sel_q and d_q are don't-care but are cleared to 0.
- Reset mid-operation discards any held beat with no output handshake.
- Output drain: drain = full & o_r[sel_q].
- Input ready: i_r = ~full | drain. This is a combinational path from o_r; it is intentional and is the full-throughput requirement.
- Accept: acc = i_v & i_r.
- Legal accept (i_sel < ways): load d_q←i_d, sel_q←i_sel, full←1. Latency 1 cycle, i_v to o_v.
- Illegal accept (i_sel ≥ ways):
  - Beat is consumed and not loaded; full←0 if drain, else unchanged.
  - err_q←1 for exactly one cycle.
  - drop_cnt←drop_cnt+1, saturating at all-ones.
- Simultaneous drain and legal accept: the new beat replaces the old one in the same edge; full stays 1.
- No accept and drain: full←0.
- o_v[k] = full & (sel_q==k). o_d lane k = d_q when o_v[k], else zero. Lanes are deterministic, not broadcast.
- Holding: o_v and o_d remain stable while the selected o_r is low. o_r of unselected lanes is ignored.
- i_v may deassert without an accept; no state change results.
- When ways is a power of two, the illegal path is unreachable: o_err stays 0 and o_drop_cnt stays 0.

Decomposition:
- Shared package base_pkg:
  - function onehot_dec(sel, ways)
  - localparam rule for sel_width
- Sub-module base_decode_le (binary to one-hot, ways outputs, plus an out-of-range flag). It generates o_v and the legality check. Keep it combinational.
- Top level holds registers and handshake logic only. Target 120–180 lines.

Test Plan:
All scenarios use width=8, ways=3, cnt_width=4.
1. Reset: hold reset_n=0 for 3 cycles with i_v=1 → o_v=000, o_d=0, o_err=0, o_drop_cnt=0; i_r=1 on the first cycle after release.
2. Single beat: i_v=1, i_sel=2, i_d=8'hA5, o_r=111 → next cycle o_v=100, lane2=A5, lanes0/1=00; one cycle later o_v=000.
3. Backpressure:
   - Load sel=1, d=0x3C with o_r=000 for 4 cycles → o_v=010 and data stable; i_r=0 while i_v=1.
   - Set o_r=101 → still held.
   - Set o_r=010 → drained next edge.
4. Back-to-back throughput: sels 0,1,2,0 with d=1,2,3,4 and o_r=111 → one beat per cycle on o_v=001,010,100,001 with matching data; i_r stays 1.
5. Illegal sel: i_sel=3, d=0xFF while empty → no o_v; o_err pulses 1 cycle; o_drop_cnt=1. Repeat 20 times → count saturates at 15.
6. Reset mid-hold: held beat on way 0 with o_r=0, assert reset_n=0 for 1 cycle → o_v=000 next cycle; o_drop_cnt=0.
